glitchfree_clkdiv: RTL and testbench
====================================

GLITCHFREE_CLKDIV -- requirements
Module: glitchfree_clkdiv

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the divide ratio and phase counter.
REQ-002 SHALL have parameter DEF_RATIO, default 4: divide ratio loaded at reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: run request for the divided clock.
REQ-006 SHALL have port req_valid, input, 1 bit: new-ratio request.
REQ-007 SHALL have port req_ratio, input, WIDTH bits: requested divide ratio.
REQ-008 SHALL have port req_ready, output, 1 bit: high when no ratio update is pending.
REQ-009 SHALL have port upd_done, output, 1 bit: one-cycle pulse when a pending ratio takes effect.
REQ-010 SHALL have port req_err, output, 1 bit: one-cycle pulse when an illegal ratio is rejected.
REQ-011 SHALL have port clk_out, output, 1 bit: registered, glitch-free divided clock.
REQ-012 SHALL have port tick, output, 1 bit: one-cycle pulse coincident with each clk_out rising edge.
REQ-013 SHALL have port running, output, 1 bit: high while the divider is not IDLE.
REQ-014 SHALL have port cur_ratio, output, WIDTH bits: the ratio currently in effect.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN_HI and RUN_LO, with clk_out=1 only in RUN_HI, driven directly from a flop.
REQ-016 SHALL, for ratio N, hold RUN_HI for ceil(N/2) cycles and RUN_LO for floor(N/2) cycles.
REQ-017 SHALL treat the last RUN_LO cycle as the period boundary.
REQ-018 SHALL move IDLE->RUN_HI one cycle after en is sampled high, with tick=1 in that first RUN_HI cycle.
REQ-019 SHALL, at a boundary with en=1, go to RUN_HI with tick=1; with en=0, go to IDLE.
REQ-020 SHALL always complete the current period when en falls mid-period; no truncated high or low phase is permitted.
REQ-021 SHALL accept a request when req_valid&&req_ready with req_ratio>=2, latching it into a pending register and dropping req_ready the next cycle.
REQ-022 SHALL, for req_ratio<2, leave req_ready unchanged, pulse req_err the next cycle, and leave cur_ratio unchanged.
REQ-023 SHALL load a pending ratio into cur_ratio only at a period boundary or while in IDLE, then pulse upd_done, raise req_ready and have the new period use the new ratio.
REQ-024 SHALL apply a request accepted in the same cycle as a boundary at the following boundary, not the current one.
REQ-025 SHALL, for a request accepted in IDLE, update cur_ratio and pulse upd_done exactly one cycle after acceptance.
REQ-026 SHALL keep the phase counter WIDTH bits wide, counting down to zero without wrap-around; ratio 2^WIDTH-1 SHALL be supported.

Reset
REQ-027 SHALL, on rst assertion, immediately force state=IDLE, clk_out=0, tick=0, running=0, cur_ratio=DEF_RATIO, pending cleared, req_ready=1, upd_done=0 and req_err=0.
REQ-028 SHALL treat reset mid-period as the only permitted truncation of clk_out; downstream logic shares rst.
REQ-029 SHALL resume operation on the first clk edge after rst deasserts, in IDLE.

Structure
REQ-030 SHALL place the FSM state enumeration and constant MIN_RATIO=2 in shared package glitchfree_pkg.
REQ-031 SHALL be implemented as a single module with no sub-module; FSM, phase counter and ratio/pending registers live together.

Verification
REQ-032 SHALL check: DEF_RATIO=4 with en=1 -> clk_out 1100 repeating, tick every 4th cycle, running=1.
REQ-033 SHALL check: ratio 5 requested in IDLE, then en=1 -> upd_done one cycle after accept; clk_out 11100 repeating.
REQ-034 SHALL check: ratio 4 running, request 6 in second RUN_HI cycle -> current period ends after 4 cycles, upd_done at that boundary, next period 111000, req_ready back to 1.
REQ-035 SHALL check: req_ratio=1 -> req_err pulses once, cur_ratio stays 4, clk_out pattern unchanged.
REQ-036 SHALL check: en dropped in first RUN_HI cycle at ratio 6 -> clk_out completes 111000, then IDLE, clk_out=0, running=0.
REQ-037 SHALL check: rst asserted mid RUN_HI -> clk_out=0 immediately and cur_ratio=DEF_RATIO; after release with en=1 the first tick occurs one cycle later.

Source files
------------

// File: rtl/glitchfree_pkg.sv
// Shared definitions for the glitch-free clock divider: FSM state encoding
// and the smallest divide ratio the divider can produce.
package glitchfree_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN_HI = 2'd1,
    ST_RUN_LO = 2'd2
  } state_e;

  localparam int unsigned MIN_RATIO = 32'd2;

endpackage

// File: rtl/glitchfree_clkdiv.sv
// Glitch-free programmable clock divider: registered clk_out with whole-period
// ratio changes and clean start/stop at period boundaries.
module glitchfree_clkdiv
  import glitchfree_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEF_RATIO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_ratio,
  output logic             req_ready,
  output logic             upd_done,
  output logic             req_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] cur_ratio
);

  localparam logic [WIDTH-1:0] DEF_RATIO_W = WIDTH'(DEF_RATIO);
  localparam logic [WIDTH-1:0] MIN_RATIO_W = WIDTH'(MIN_RATIO);
  localparam logic [WIDTH-1:0] ONE_W       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W      = {WIDTH{1'b0}};

  // Counter preloads are phase length minus one so the last cycle sees zero.
  function automatic logic [WIDTH-1:0] hi_load(input logic [WIDTH-1:0] r);
    return (r - ONE_W) >> 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] lo_load(input logic [WIDTH-1:0] r);
    return (r >> 1'b1) - ONE_W;
  endfunction

  state_e           state_r, state_next_s;
  logic [WIDTH-1:0] cnt_r, cnt_next_s;
  logic [WIDTH-1:0] cur_ratio_r, pend_r, eff_ratio_s;
  logic             pend_valid_r, req_ready_r, upd_done_r, req_err_r;
  logic             clk_out_r, tick_r, running_r, tick_next_s;
  logic             boundary_s, apply_s, accept_s, reject_s;

  assign boundary_s  = (state_r == ST_RUN_LO) && (cnt_r == ZERO_W);
  assign apply_s     = pend_valid_r && ((state_r == ST_IDLE) || boundary_s);
  assign accept_s    = req_valid && req_ready_r && (req_ratio >= MIN_RATIO_W);
  assign reject_s    = req_valid && req_ready_r && (req_ratio < MIN_RATIO_W);
  assign eff_ratio_s = apply_s ? pend_r : cur_ratio_r;

  // Next-state, phase counter and tick decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    tick_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_next_s = ST_RUN_HI;
          cnt_next_s   = hi_load(eff_ratio_s);
          tick_next_s  = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
          cnt_next_s   = ZERO_W;
        end
      end
      ST_RUN_HI: begin
        if (cnt_r == ZERO_W) begin
          state_next_s = ST_RUN_LO;
          cnt_next_s   = lo_load(cur_ratio_r);
        end else begin
          cnt_next_s   = cnt_r - ONE_W;
        end
      end
      ST_RUN_LO: begin
        if (cnt_r != ZERO_W) begin
          cnt_next_s   = cnt_r - ONE_W;
        end else if (en) begin
          state_next_s = ST_RUN_HI;
          cnt_next_s   = hi_load(eff_ratio_s);
          tick_next_s  = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
          cnt_next_s   = ZERO_W;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = ZERO_W;
      end
    endcase
  end

  // FSM state, counter and clock outputs, all flop-driven from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= ZERO_W;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      clk_out_r <= (state_next_s == ST_RUN_HI);
      tick_r    <= tick_next_s;
      running_r <= (state_next_s != ST_IDLE);
    end
  end

  // Ratio request handshake; a pending ratio is only committed between periods.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_ratio_r  <= DEF_RATIO_W;
      pend_r       <= ZERO_W;
      pend_valid_r <= 1'b0;
      req_ready_r  <= 1'b1;
      upd_done_r   <= 1'b0;
      req_err_r    <= 1'b0;
    end else begin
      upd_done_r <= apply_s;
      req_err_r  <= reject_s;
      if (accept_s) begin
        pend_r       <= req_ratio;
        pend_valid_r <= 1'b1;
        req_ready_r  <= 1'b0;
      end else if (apply_s) begin
        cur_ratio_r  <= pend_r;
        pend_valid_r <= 1'b0;
        req_ready_r  <= 1'b1;
      end
    end
  end

  assign clk_out   = clk_out_r;
  assign tick      = tick_r;
  assign running   = running_r;
  assign cur_ratio = cur_ratio_r;
  assign req_ready = req_ready_r;
  assign upd_done  = upd_done_r;
  assign req_err   = req_err_r;

endmodule

// File: tb/tb_glitchfree_clkdiv.sv
// Self-checking bench for glitchfree_clkdiv: directed sequences, a vector
// table and randomized traffic against a period-position reference model.
module tb_glitchfree_clkdiv;

  logic       clk, rst, en, req_valid;
  logic [7:0] req_ratio;
  logic       req_ready, upd_done, req_err, clk_out, tick, running;
  logic [7:0] cur_ratio;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position inside the current period plus ratio bookkeeping.
  bit m_run, m_tick, m_upd, m_err;
  int m_pos, m_n, m_cur, m_pend;

  typedef struct {
    logic       en;
    logic       rv;
    logic [7:0] r;
    logic       e_clk;
    logic       e_tick;
    logic       e_run;
    logic       e_rdy;
    logic       e_upd;
    logic       e_err;
    logic [7:0] e_cur;
  } vec_t;

  vec_t tbl [21];

  glitchfree_clkdiv #(.WIDTH(8), .DEF_RATIO(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ratio (req_ratio),
    .req_ready (req_ready),
    .upd_done  (upd_done),
    .req_err   (req_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .cur_ratio (cur_ratio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pos = 0; m_n = 4; m_cur = 4; m_pend = -1;
    m_tick = 1'b0; m_upd = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit boundary, apply, acc;
    int newcur;
    boundary = m_run && (m_pos == m_n - 1);
    apply    = (m_pend >= 0) && (!m_run || boundary);
    newcur   = apply ? m_pend : m_cur;
    acc      = req_valid && (m_pend < 0) && (int'(req_ratio) >= 2);
    m_err    = req_valid && (m_pend < 0) && (int'(req_ratio) < 2);
    m_upd    = apply;
    m_tick   = 1'b0;
    if (!m_run) begin
      if (en) begin m_run = 1'b1; m_pos = 0; m_n = newcur; m_tick = 1'b1; end
    end else if (boundary) begin
      if (en) begin m_pos = 0; m_n = newcur; m_tick = 1'b1; end
      else m_run = 1'b0;
    end else begin
      m_pos++;
    end
    m_cur = newcur;
    if (acc) m_pend = int'(req_ratio);
    else if (apply) m_pend = -1;
  endtask

  task automatic model_check();
    bit exp_clk;
    exp_clk = m_run && (m_pos < (m_n + 1) / 2);
    chk("m_clk_out",   clk_out,   exp_clk);
    chk("m_tick",      tick,      m_tick);
    chk("m_running",   running,   m_run);
    chk("m_req_ready", req_ready, m_pend < 0);
    chk("m_upd_done",  upd_done,  m_upd);
    chk("m_req_err",   req_err,   m_err);
    chk("m_cur_ratio", cur_ratio, m_cur);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    model_check();
  endtask

  initial begin
    bit got;
    int hi_cnt, p;

    //                en    rv    r      clk   tick  run   rdy   upd   err   cur
    tbl[0]  = '{1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6};
    tbl[1]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5};
    tbl[2]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
    tbl[3]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
    tbl[4]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
    tbl[5]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
    tbl[6]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
    tbl[7]  = '{1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5};
    tbl[8]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
    tbl[9]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
    tbl[10] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
    tbl[11] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
    tbl[12] = '{1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5};
    tbl[13] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5};
    tbl[14] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5};
    tbl[15] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5};
    tbl[16] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5};
    tbl[17] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3};
    tbl[18] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
    tbl[19] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
    tbl[20] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};

    rst = 1'b1; en = 1'b0; req_valid = 1'b0; req_ratio = 8'd0;
    model_reset();
    cycle();
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_cur_ratio", cur_ratio, 8'd4);
    cycle();
    rst = 1'b0;
    cycle();

    // Default ratio 4 free-running: 1100 with a tick every fourth cycle.
    en = 1'b1;
    for (p = 0; p < 12; p++) begin
      cycle();
      chk("def_clk_out", clk_out, (p % 4) < 2);
      chk("def_tick", tick, (p % 4) == 0);
      chk("def_running", running, 1'b1);
    end

    // Illegal ratio is rejected without disturbing the running pattern.
    req_valid = 1'b1; req_ratio = 8'd1;
    cycle();
    chk("err_pulse", req_err, 1'b1);
    chk("err_ready", req_ready, 1'b1);
    chk("err_clk_out", clk_out, (p % 4) < 2);
    req_valid = 1'b0; p++;
    cycle();
    chk("err_single", req_err, 1'b0);
    chk("err_cur_ratio", cur_ratio, 8'd4);
    chk("err_clk_out2", clk_out, (p % 4) < 2);

    // Move to ratio 3, then reset asynchronously in a high phase.
    req_valid = 1'b1; req_ratio = 8'd3;
    cycle();
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin cycle(); if (upd_done) got = 1'b1; end
    chk("r3_upd_seen", got, 1'b1);
    chk("r3_cur_ratio", cur_ratio, 8'd3);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin cycle(); if (clk_out) got = 1'b1; end
    chk("rst_mid_hi_found", got, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_clk_out", clk_out, 1'b0);
    chk("arst_cur_ratio", cur_ratio, 8'd4);
    chk("arst_running", running, 1'b0);
    cycle();
    rst = 1'b0; en = 1'b1;
    cycle();
    chk("arst_first_tick", tick, 1'b1);
    chk("arst_first_clk", clk_out, 1'b1);

    // Ratio change requested in the second high cycle waits for the boundary.
    cycle();
    chk("chg_hi2_clk", clk_out, 1'b1);
    req_valid = 1'b1; req_ratio = 8'd6;
    cycle();
    req_valid = 1'b0;
    chk("chg_lo1_ready", req_ready, 1'b0);
    chk("chg_lo1_clk", clk_out, 1'b0);
    cycle();
    chk("chg_lo2_clk", clk_out, 1'b0);
    chk("chg_lo2_cur", cur_ratio, 8'd4);
    cycle();
    chk("chg_upd", upd_done, 1'b1);
    chk("chg_tick", tick, 1'b1);
    chk("chg_cur", cur_ratio, 8'd6);
    chk("chg_ready", req_ready, 1'b1);
    for (int i = 1; i < 6; i++) begin cycle(); chk("r6_clk_out", clk_out, i < 3); end

    // Drop en in the first high cycle: the period still completes as 111000.
    cycle();
    chk("stop_tick", tick, 1'b1);
    en = 1'b0;
    for (int i = 1; i < 6; i++) begin
      cycle();
      chk("stop_clk_out", clk_out, i < 3);
      chk("stop_running", running, 1'b1);
    end
    cycle();
    chk("stop_idle_clk", clk_out, 1'b0);
    chk("stop_idle_run", running, 1'b0);

    for (int i = 0; i < 21; i++) begin
      en = tbl[i].en; req_valid = tbl[i].rv; req_ratio = tbl[i].r;
      cycle();
      chk($sformatf("tbl%0d_clk", i), clk_out, tbl[i].e_clk);
      chk($sformatf("tbl%0d_tick", i), tick, tbl[i].e_tick);
      chk($sformatf("tbl%0d_run", i), running, tbl[i].e_run);
      chk($sformatf("tbl%0d_rdy", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_upd", i), upd_done, tbl[i].e_upd);
      chk($sformatf("tbl%0d_err", i), req_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_cur", i), cur_ratio, tbl[i].e_cur);
    end
    req_valid = 1'b0;

    // Largest ratio: 128 high cycles then 127 low.
    req_valid = 1'b1; req_ratio = 8'd255;
    cycle();
    req_valid = 1'b0;
    cycle();
    chk("max_cur", cur_ratio, 8'd255);
    en = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 255; i++) begin cycle(); if (clk_out) hi_cnt++; end
    chk("max_hi_count", hi_cnt, 128);
    cycle();
    chk("max_next_tick", tick, 1'b1);

    for (int k = 0; k < 3000; k++) begin
      int sel;
      en        = ($urandom_range(0, 9) != 0);
      req_valid = ($urandom_range(0, 7) == 0);
      sel       = $urandom_range(0, 9);
      req_ratio = (sel == 9) ? 8'd255 : 8'(sel);
      cycle();
    end

    en = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 600 && running; i++) cycle();
    chk("drain_idle", running, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
